// File: rtl/mvm_stream_mxn_if.sv
// Stream bundle for mvm_stream_mxn: command pulses, operand input stream, result output stream, status.
// master = data source / controller side, slave = matrix-vector engine side.
interface mvm_stream_mxn_if #(
    parameter int unsigned B  = 8,
    parameter int unsigned AW = 20
);
    logic                 load_matrix;
    logic                 load_vector;
    logic                 start;
    logic                 s_valid;
    logic signed [B-1:0]  s_data;
    logic                 s_ready;
    logic                 m_valid;
    logic signed [AW-1:0] m_data;
    logic                 m_ready;
    logic                 busy;
    logic                 done;

    modport master (
        output load_matrix, load_vector, start, s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, busy, done
    );

    modport slave (
        input  load_matrix, load_vector, start, s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, busy, done
    );
endinterface

// File: rtl/mvm_stream_mxn.sv
// Streaming y = A*x engine over P lockstep MAC lanes with optional product register (G).
// Define MVM_SAT_EN to clamp each result to the signed 2B-bit range before it is buffered.
module mvm_stream_mxn #(
    parameter int unsigned M  = 12,
    parameter int unsigned N  = 12,
    parameter int unsigned B  = 8,
    parameter int unsigned P  = 1,
    parameter int unsigned G  = 1,
    parameter int unsigned AW = 2*B + $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    mvm_stream_mxn_if.slave  bus
);
    localparam int unsigned RPL  = M / P;
    localparam int unsigned LDEP = RPL * N;
    localparam int unsigned AAW  = (LDEP > 1) ? $clog2(LDEP) : 1;
    localparam int unsigned CW   = (N > 1)    ? $clog2(N)    : 1;
    localparam int unsigned RW   = (RPL > 1)  ? $clog2(RPL)  : 1;
    localparam int unsigned LW   = (P > 1)    ? $clog2(P)    : 1;
    localparam int unsigned IW   = (M > 1)    ? $clog2(M)    : 1;

    if ((M % P) != 0) begin : g_bad_p
        $error("mvm_stream_mxn: M must be a multiple of P");
    end
    if (G > 1) begin : g_bad_g
        $error("mvm_stream_mxn: G must be 0 or 1");
    end

`ifdef MVM_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-2*B+1){1'b0}}, {(2*B-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-2*B+1){1'b1}}, {(2*B-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_X, S_COMPUTE, S_DRAIN, S_OUTPUT
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        col_q;
    logic [RW-1:0]        grp_q;
    logic [LW-1:0]        lane_q;
    logic [IW-1:0]        out_idx_q;
    logic                 drain_q;
    logic                 s_ready_q;
    logic                 m_valid_q;
    logic signed [AW-1:0] m_data_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 beat_c;
    logic                 a_we_c;
    logic [AAW-1:0]       addr_c;

    logic                 rd_v_q, rd_first_q, rd_last_q;
    logic [RW-1:0]        rd_grp_q;
    logic                 mac_v_c, mac_first_c, mac_last_c;
    logic [RW-1:0]        mac_grp_c;

    logic signed [B-1:0]  x_mem [N];
    logic signed [B-1:0]  x_rd_q;
    logic signed [AW-1:0] lane_sum_c [P];
    logic signed [AW-1:0] res_q [M];

    assign beat_c = bus.s_valid & s_ready_q;
    assign a_we_c = beat_c && (state_q == S_LOAD_A);
    // One address serves both loading and computing: row group * N + column.
    assign addr_c = AAW'(int'(grp_q) * int'(N) + int'(col_q));

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    function automatic logic signed [AW-1:0] fmt_result(input logic signed [AW-1:0] v);
`ifdef MVM_SAT_EN
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
`endif
        return v;
    endfunction

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            grp_q     <= '0;
            lane_q    <= '0;
            out_idx_q <= '0;
            drain_q   <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    col_q     <= '0;
                    grp_q     <= '0;
                    lane_q    <= '0;
                    out_idx_q <= '0;
                    drain_q   <= 1'b0;
                    if (bus.load_matrix) begin
                        state_q   <= S_LOAD_A;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (bus.load_vector) begin
                        state_q   <= S_LOAD_X;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (bus.start) begin
                        state_q <= S_COMPUTE;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD_A: begin
                    // Row-major beats: column, then lane (r % P), then row group (r / P).
                    if (beat_c) begin
                        if (col_q == CW'(N-1)) begin
                            col_q <= '0;
                            if (lane_q == LW'(P-1)) begin
                                lane_q <= '0;
                                if (grp_q == RW'(RPL-1)) begin
                                    grp_q     <= '0;
                                    state_q   <= S_IDLE;
                                    s_ready_q <= 1'b0;
                                    busy_q    <= 1'b0;
                                end else begin
                                    grp_q <= grp_q + RW'(1);
                                end
                            end else begin
                                lane_q <= lane_q + LW'(1);
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                S_LOAD_X: begin
                    if (beat_c) begin
                        if (col_q == CW'(N-1)) begin
                            col_q     <= '0;
                            state_q   <= S_IDLE;
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (col_q == CW'(N-1)) begin
                        col_q <= '0;
                        if (grp_q == RW'(RPL-1)) begin
                            grp_q   <= '0;
                            state_q <= S_DRAIN;
                            drain_q <= 1'b0;
                        end else begin
                            grp_q <= grp_q + RW'(1);
                        end
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_q == 1'(G)) begin
                        state_q <= S_OUTPUT;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                S_OUTPUT: begin
                    // First OUTPUT cycle presents y[0]; afterwards advance on each handshake.
                    if (!m_valid_q) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= res_q[out_idx_q];
                    end else if (bus.m_ready) begin
                        if (out_idx_q == IW'(M-1)) begin
                            m_valid_q <= 1'b0;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            out_idx_q <= '0;
                            state_q   <= S_IDLE;
                        end else begin
                            out_idx_q <= out_idx_q + IW'(1);
                            m_data_q  <= res_q[out_idx_q + IW'(1)];
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read-stage tags travelling alongside the storage read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v_q     <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_grp_q   <= '0;
        end else begin
            rd_v_q     <= (state_q == S_COMPUTE);
            rd_first_q <= (col_q == '0);
            rd_last_q  <= (col_q == CW'(N-1));
            rd_grp_q   <= grp_q;
        end
    end

    if (G == 1) begin : g_tag_pipe
        logic          pv_q, pf_q, pl_q;
        logic [RW-1:0] pg_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pv_q <= 1'b0;
                pf_q <= 1'b0;
                pl_q <= 1'b0;
                pg_q <= '0;
            end else begin
                pv_q <= rd_v_q;
                pf_q <= rd_first_q;
                pl_q <= rd_last_q;
                pg_q <= rd_grp_q;
            end
        end
        assign mac_v_c     = pv_q;
        assign mac_first_c = pf_q;
        assign mac_last_c  = pl_q;
        assign mac_grp_c   = pg_q;
    end else begin : g_tag_direct
        assign mac_v_c     = rd_v_q;
        assign mac_first_c = rd_first_q;
        assign mac_last_c  = rd_last_q;
        assign mac_grp_c   = rd_grp_q;
    end

    // Vector storage is shared; every lane sees the same x element each cycle.
    always_ff @(posedge clk) begin
        if (beat_c && (state_q == S_LOAD_X)) x_mem[col_q] <= bus.s_data;
        if (state_q == S_COMPUTE)            x_rd_q       <= x_mem[col_q];
    end

    for (genvar l = 0; l < P; l++) begin : g_lane
        logic signed [B-1:0]   mem [LDEP];
        logic signed [B-1:0]   a_rd_q;
        logic signed [2*B-1:0] prod_c;
        logic signed [2*B-1:0] mac_prod_c;
        logic signed [AW-1:0]  acc_q;

        always_ff @(posedge clk) begin
            if (a_we_c && (lane_q == LW'(l))) mem[addr_c] <= bus.s_data;
            if (state_q == S_COMPUTE)         a_rd_q      <= mem[addr_c];
            if (mac_v_c)                      acc_q       <= lane_sum_c[l];
        end

        assign prod_c = (2*B)'(a_rd_q) * (2*B)'(x_rd_q);

        if (G == 1) begin : g_preg
            logic signed [2*B-1:0] prod_q;
            always_ff @(posedge clk) prod_q <= prod_c;
            assign mac_prod_c = prod_q;
        end else begin : g_nopreg
            assign mac_prod_c = prod_c;
        end

        assign lane_sum_c[l] = mac_first_c ? AW'(mac_prod_c) : acc_q + AW'(mac_prod_c);
    end

    // Lane l of row group g owns result row g*P + l.
    always_ff @(posedge clk) begin
        if (mac_v_c && mac_last_c) begin
            for (int l = 0; l < int'(P); l++) begin
                res_q[IW'(int'(mac_grp_c) * int'(P) + l)] <= fmt_result(lane_sum_c[l]);
            end
        end
    end
endmodule

// File: tb/tb_mvm_stream_mxn.sv
// Bench for mvm_stream_mxn: a P=1 and a P=4 instance share stimulus; a reference model feeds per-instance queues.
module tb_mvm_stream_mxn;
    localparam int unsigned M  = 12;
    localparam int unsigned N  = 12;
    localparam int unsigned B  = 8;
    localparam int unsigned AW = 2*B + $clog2(N);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                load_matrix, load_vector, s_valid, m_ready;
    logic                start0, start1;
    logic signed [B-1:0] s_data;

    mvm_stream_mxn_if #(.B(B), .AW(AW)) bus0 ();
    mvm_stream_mxn_if #(.B(B), .AW(AW)) bus1 ();

    assign bus0.load_matrix = load_matrix;
    assign bus0.load_vector = load_vector;
    assign bus0.start       = start0;
    assign bus0.s_valid     = s_valid;
    assign bus0.s_data      = s_data;
    assign bus0.m_ready     = m_ready;
    assign bus1.load_matrix = load_matrix;
    assign bus1.load_vector = load_vector;
    assign bus1.start       = start1;
    assign bus1.s_valid     = s_valid;
    assign bus1.s_data      = s_data;
    assign bus1.m_ready     = m_ready;

    mvm_stream_mxn #(.M(M), .N(N), .B(B), .P(1), .G(1), .AW(AW)) u_p1 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    mvm_stream_mxn #(.M(M), .N(N), .B(B), .P(4), .G(1), .AW(AW)) u_p4 (
        .clk(clk), .reset(reset), .bus(bus1.slave));

    logic                 mv [2];
    logic                 sr [2];
    logic                 bz [2];
    logic                 dn [2];
    logic signed [AW-1:0] md [2];
    assign mv[0] = bus0.m_valid;  assign mv[1] = bus1.m_valid;
    assign sr[0] = bus0.s_ready;  assign sr[1] = bus1.s_ready;
    assign bz[0] = bus0.busy;     assign bz[1] = bus1.busy;
    assign dn[0] = bus0.done;     assign dn[1] = bus1.done;
    assign md[0] = bus0.m_data;   assign md[1] = bus1.m_data;

    int     n_chk = 0;
    int     n_err = 0;
    longint cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     a_m [M][N];
    int     x_v [N];
    longint exp_q0 [$];
    longint exp_q1 [$];

    longint               start_cyc [2];
    bit                   lat_pend  [2];
    int                   done_cnt  [2];
    longint               hs_cyc    [2];
    bit                   hold_pend [2];
    logic signed [AW-1:0] hold_val  [2];
    int                   exp_lat   [2];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: scoreboard pop on handshake, hold check while stalled, latency and done timing.
    always @(negedge clk) begin
        longint e;
        int     qs;
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                if (hold_pend[d]) begin
                    check_val(d == 0 ? "hold_valid_p1" : "hold_valid_p4", longint'(mv[d]), 1);
                    check_val(d == 0 ? "hold_data_p1" : "hold_data_p4", md[d], hold_val[d]);
                    hold_pend[d] = 1'b0;
                end
                if (mv[d] && lat_pend[d]) begin
                    check_val(d == 0 ? "latency_p1" : "latency_p4", cyc - start_cyc[d], exp_lat[d]);
                    lat_pend[d] = 1'b0;
                end
                qs = (d == 0) ? exp_q0.size() : exp_q1.size();
                if (mv[d] && m_ready) begin
                    if (qs == 0) begin
                        check_val(d == 0 ? "extra_result_p1" : "extra_result_p4", 1, 0);
                    end else begin
                        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check_val(d == 0 ? "y_p1" : "y_p4", md[d], e);
                    end
                    hs_cyc[d] = cyc;
                end else if (mv[d]) begin
                    hold_pend[d] = 1'b1;
                    hold_val[d]  = md[d];
                end
                if (dn[d]) begin
                    done_cnt[d]++;
                    check_val(d == 0 ? "done_after_last_p1" : "done_after_last_p4", cyc - hs_cyc[d], 1);
                    check_val(d == 0 ? "done_queue_p1" : "done_queue_p4", longint'(qs), 0);
                end
            end
        end
    end

    task automatic push_model();
        longint s;
        logic signed [AW-1:0] w;
        longint e;
        for (int r = 0; r < int'(M); r++) begin
            s = 0;
            for (int c = 0; c < int'(N); c++) s += longint'(a_m[r][c]) * longint'(x_v[c]);
            w = AW'(s);
            e = w;
`ifdef MVM_SAT_EN
            if (e > 32767)  e = 32767;
            if (e < -32768) e = -32768;
`endif
            exp_q0.push_back(e);
            exp_q1.push_back(e);
        end
    endtask

    task automatic send_beat(input int val);
        bit got;
        got     = 1'b0;
        s_valid = 1'b1;
        s_data  = B'(val);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = sr[0] && sr[1];
            @(posedge clk);
            #1;
        end
        check_val("beat_accepted", longint'(got), 1);
        s_valid = 1'b0;
    endtask

    task automatic load(input bit mat, input bit with_start);
        if (mat) load_matrix = 1'b1; else load_vector = 1'b1;
        if (with_start) begin start0 = 1'b1; start1 = 1'b1; end
        @(posedge clk);
        #1;
        load_matrix = 1'b0; load_vector = 1'b0; start0 = 1'b0; start1 = 1'b0;
        if (with_start) begin
            check_val("cmd_prio_ready", longint'(sr[0] & sr[1]), 1);
            check_val("cmd_prio_busy", longint'(bz[0] & bz[1]), 1);
        end
        for (int k = 0; k < (mat ? int'(M*N) : int'(N)); k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_beat(mat ? a_m[k / int'(N)][k % int'(N)] : x_v[k]);
        end
        @(negedge clk);
        check_val("load_end_ready", longint'(sr[0] | sr[1]), 0);
        check_val("load_end_busy", longint'(bz[0] | bz[1]), 0);
    endtask

    task automatic run(input bit toggle, input bit stray);
        bit sd [2];
        sd[0] = 1'b0; sd[1] = 1'b0;
        start0 = 1'b1; start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0; start1 = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_cyc[d] = cyc;
            lat_pend[d]  = 1'b1;
            done_cnt[d]  = 0;
        end
        for (int k = 0; k < 400; k++) begin
            if (done_cnt[0] > 0 && done_cnt[1] > 0) break;
            if (toggle) m_ready = ~m_ready;
            start0 = stray && mv[0] && !sd[0];
            start1 = stray && mv[1] && !sd[1];
            if (start0) sd[0] = 1'b1;
            if (start1) sd[1] = 1'b1;
            @(posedge clk);
            #1;
        end
        start0 = 1'b0; start1 = 1'b0; m_ready = 1'b1;
        check_val("run_complete", longint'(done_cnt[0] > 0 && done_cnt[1] > 0), 1);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_val(d == 0 ? "done_once_p1" : "done_once_p4", done_cnt[d], 1);
            check_val(d == 0 ? "idle_busy_p1" : "idle_busy_p4", longint'(bz[d]), 0);
        end
        check_val("queue_empty", longint'(exp_q0.size() + exp_q1.size()), 0);
    endtask

    initial begin
        exp_lat[0] = 147;
        exp_lat[1] = 39;
        for (int d = 0; d < 2; d++) begin
            lat_pend[d] = 1'b0; hold_pend[d] = 1'b0; done_cnt[d] = 0; hs_cyc[d] = 0; start_cyc[d] = 0;
        end
        reset = 1'b1;
        load_matrix = 1'b0; load_vector = 1'b0; start0 = 1'b0; start1 = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_val("rst_s_ready", longint'(sr[d]), 0);
            check_val("rst_m_valid", longint'(mv[d]), 0);
            check_val("rst_busy", longint'(bz[d]), 0);
            check_val("rst_done", longint'(dn[d]), 0);
            check_val("rst_m_data", md[d], 0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a matrix load.
        load_matrix = 1'b1;
        @(posedge clk);
        #1;
        load_matrix = 1'b0;
        for (int k = 0; k < 5; k++) send_beat(k);
        #2;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_val("abort_s_ready", longint'(sr[d]), 0);
            check_val("abort_busy", longint'(bz[d]), 0);
            check_val("abort_m_valid", longint'(mv[d]), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_abort_busy", longint'(bz[0] | bz[1]), 0);
        check_val("post_abort_ready", longint'(sr[0] | sr[1]), 0);
        s_valid = 1'b0;

        // Identity matrix, x = 1..12, sink always ready.
        for (int r = 0; r < int'(M); r++)
            for (int c = 0; c < int'(N); c++) a_m[r][c] = (r == c) ? 1 : 0;
        for (int c = 0; c < int'(N); c++) x_v[c] = c + 1;
        load(1'b1, 1'b0);
        load(1'b0, 1'b0);
        push_model();
        run(1'b0, 1'b0);

        // Same data, alternating backpressure, stray start while outputting.
        push_model();
        run(1'b1, 1'b1);
        repeat (170) @(posedge clk);
        #1;
        check_val("stray_start_busy", longint'(bz[0] | bz[1]), 0);

        // A[r][c] = r+1, x = all ones.
        for (int r = 0; r < int'(M); r++)
            for (int c = 0; c < int'(N); c++) a_m[r][c] = r + 1;
        for (int c = 0; c < int'(N); c++) x_v[c] = 1;
        load(1'b1, 1'b0);
        load(1'b0, 1'b0);
        push_model();
        run(1'b0, 1'b0);

        // Most negative operands everywhere: exceeds 2B-bit range.
        for (int r = 0; r < int'(M); r++)
            for (int c = 0; c < int'(N); c++) a_m[r][c] = -128;
        for (int c = 0; c < int'(N); c++) x_v[c] = -128;
        load(1'b1, 1'b0);
        load(1'b0, 1'b0);
        push_model();
        run(1'b0, 1'b0);

        // load_matrix and start together: load wins, start is dropped.
        for (int r = 0; r < int'(M); r++)
            for (int c = 0; c < int'(N); c++) a_m[r][c] = r - c;
        load(1'b1, 1'b1);
        repeat (200) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_val("prio_no_compute_busy", longint'(bz[d]), 0);
            check_val("prio_no_compute_valid", longint'(mv[d]), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mvm_stream_mxn.md
Name: mvm_stream_mxn

Overview:
- Parametrised matrix-vector multiplier computing y = A·x.
- A is an M×N signed matrix; x is an N-entry signed vector.
- Work is spread over P parallel MAC lanes, with an optional pipeline register in each MAC.
- Operands stream in and results stream out over valid/ready handshakes. The block is the successor of the fixed square single-lane mvm engine and sits between the data-source FIFO and the result sink.

Parameters:
- M, 12: matrix rows = output length.
- N, 12: matrix columns = vector length.
- B, 8: signed input element width.
- P, 1: MAC lanes; M % P == 0 is required, enforced by an elaboration-time check.
- G, 1: MAC pipeline stages; legal values are 0 and 1.
- AW, 2*B+$clog2(N): accumulator and result width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- load_matrix  in  1  command pulse: load A.
- load_vector  in  1  command pulse: load x.
- start  in  1  command pulse: compute.
- s_valid  in  1  input beat valid.
- s_data  in  B  signed input element.
- s_ready  out  1  block accepts an input beat.
- m_valid  out  1  result valid.
- m_data  out  AW  signed result y[i].
- m_ready  in  1  sink accepts the result.
- busy  out  1  FSM is not in IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE; all counters go to 0.
  - s_ready, m_valid, busy and done are 0; m_data is 0.
  - A and x storage is not reset and keeps its contents.
- FSM states: IDLE, LOAD_A, LOAD_X, COMPUTE, DRAIN, OUTPUT.
- IDLE:
  - Command priority: load_matrix > load_vector > start.
  - Commands are sampled only in IDLE and ignored in every other state.
- LOAD_A:
  - s_ready=1; a beat is accepted on s_valid&s_ready.
  - Order is row-major: beat r*N+c holds A[r][c].
  - Row r is stored in lane r%P at local address (r/P)*N+c.
  - After M*N beats, go to IDLE on the next edge.
- LOAD_X:
  - s_ready=1; N beats, broadcast to every lane.
  - After the last beat, go to IDLE.
- s_valid outside LOAD_A/LOAD_X: s_ready=0 and the data is ignored.
- COMPUTE:
  - Lanes run in lockstep; each lane processes M/P rows of N cycles each.
  - Storage read latency is 1 cycle. The product is signed B×B → 2B, sign-extended to AW.
  - The accumulator clears at the start of each row. With G=1, the product register adds one cycle.
  - Accumulation wraps modulo 2^AW.
  - Each completed row result is written to a result buffer of M entries at index r.
  - After (M/P)*N cycles, go to DRAIN.
- DRAIN:
  - Lasts G+1 cycles to flush the read and MAC pipelines, then goes to OUTPUT.
- Latency: the first m_valid rises exactly (M/P)*N+G+2 cycles after the edge that sampled start.
- OUTPUT:
  - m_valid=1 and m_data=y[i], for i = 0..M-1 in order.
  - i advances on m_valid&m_ready.
  - While m_ready=0, m_valid and m_data are held stable.
  - After the final handshake: m_valid falls, done=1 for exactly one cycle, FSM goes to IDLE.
- busy=1 in every state except IDLE.
- A start with no prior load computes on the retained storage contents; after power-up these contents are undefined.
- Reset asserted mid-operation aborts immediately; no done pulse is produced.
- The result buffer keeps a partially drained output until the next COMPUTE overwrites it.

Optional Feature:
- Macro: MVM_SAT_EN.
- Defined: each result is clamped to the signed 2B-bit range [-(2^(2B-1)), 2^(2B-1)-1] before the result buffer write, then sign-extended onto m_data.
- Undefined: the full AW-bit wrapped result is presented.

Test Plan:
1. Reset pulse mid-LOAD_A after 5 beats (async, between edges) → immediately s_ready=0, busy=0, m_valid=0; a following start-free cycle stays in IDLE.
2. M=N=12, P=1, G=1: A=identity, x=1..12, start → first m_valid 147 cycles after start; y=1,2,…,12 with m_ready=1; done one cycle after y[11].
3. M=N=12, P=4, G=1: A[r][c]=r+1, x=all 1 → first m_valid after 39 cycles; y[r]=12*(r+1), i.e. 12,24,…,144.
4. Case 2 with m_ready pattern 1,0,1,0… → each y held while m_ready=0, order preserved, done exactly once after the 12th handshake.
5. B=8, N=12: A=all -128, x=all -128 → y=196608 without MVM_SAT_EN; y=32767 with MVM_SAT_EN.
6. load_matrix and start high in the same IDLE cycle → LOAD_A entered, start dropped; start pulsed during OUTPUT → ignored, no second result stream.
